onewire_master: RTL

Synthesizable 1-Wire bus master sequencing reset/presence, write-slot and read-slot timing on a single open-drain line, with byte-level commands from a host. Sits between a host controller (register interface or local FSM) and the board-level 1-Wire pin, and drives DS1822/DS2401-class devices. All timing is derived from a microsecond prescaler, so the block is clock-rate independent.

---
 rtl/onewire_pkg.sv | 45 ++++
 rtl/onewire_us_tick.sv | 51 +++++
 rtl/onewire_master.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/onewire_pkg.sv
// Shared definitions for the 1-Wire master: op-codes, slot/reset timing in
// microseconds, FSM state encoding and small timing helpers.
package onewire_pkg;

   localparam logic [1:0] OP_RESET      = 2'd0;
   localparam logic [1:0] OP_WRITE_BYTE = 2'd1;
   localparam logic [1:0] OP_READ_BYTE  = 2'd2;
   localparam logic [1:0] OP_BIT        = 2'd3;

   localparam int unsigned T_RSTL      = 480;
   localparam int unsigned T_PRES_SAMP = 70;
   localparam int unsigned T_RST_REC   = 410;
   localparam int unsigned T_LOW1      = 6;
   localparam int unsigned T_LOW0      = 60;
   localparam int unsigned T_RD_SAMP   = 15;
   localparam int unsigned T_SLOT      = 70;
   localparam int unsigned T_REC       = 5;

   localparam int US_W = 10;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RST_LOW   = 3'd1,
      RST_SAMP  = 3'd2,
      RST_REC   = 3'd3,
      SLOT_LOW  = 3'd4,
      SLOT_HIGH = 3'd5,
      SLOT_REC  = 3'd6,
      DONE      = 3'd7
   } ow_state_t;

   // True on the last cycle of a dur_us interval that started at a prescaler restart,
   // so a state left on this condition lasts exactly dur_us * CLK_PER_US cycles.
   function automatic logic us_expired(input logic tick,
                                       input logic [US_W-1:0] us_count,
                                       input int unsigned dur_us);
      return tick && (us_count == US_W'(dur_us - 1));
   endfunction

   // Read slots always transmit a 1 so the slave can pull the line.
   function automatic logic slot_bit(input logic [1:0] op, input logic data_bit);
      return (op == OP_READ_BYTE) ? 1'b1 : data_bit;
   endfunction

endpackage

// File: rtl/onewire_us_tick.sv
// Microsecond prescaler: restartable cycle divider with a saturating count of
// whole microseconds elapsed since the last restart.
module onewire_us_tick
   import onewire_pkg::*;
#(
   parameter int unsigned CLK_PER_US = 50
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            restart,
   output logic            tick,
   output logic [US_W-1:0] us_count
);

   localparam int unsigned     CYC_W    = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
   localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLK_PER_US - 1);
   localparam logic [US_W-1:0]  US_MAX   = '1;

   logic [CYC_W-1:0] cyc_reg, cyc_next;
   logic [US_W-1:0]  us_reg, us_next;

   always_comb begin
      cyc_next = cyc_reg;
      us_next  = us_reg;
      if (restart) begin
         cyc_next = '0;
         us_next  = '0;
      end else if (cyc_reg == CYC_LAST) begin
         cyc_next = '0;
         if (us_reg != US_MAX) begin
            us_next = us_reg + 1'b1;
         end
      end else begin
         cyc_next = cyc_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cyc_reg <= '0;
         us_reg  <= '0;
      end else begin
         cyc_reg <= cyc_next;
         us_reg  <= us_next;
      end
   end

   assign tick     = (cyc_reg == CYC_LAST);
   assign us_count = us_reg;

endmodule

// File: rtl/onewire_master.sv
// 1-Wire bus master: sequences reset/presence, write and read slots on an
// open-drain line and reports one response per host command.
module onewire_master
   import onewire_pkg::*;
#(
   parameter int unsigned CLK_PER_US = 50
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [7:0] cmd_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       rsp_presence,
   output logic       rsp_err,
   output logic       ow_drive,
   input  logic       ow_in
);

   ow_state_t       state_reg, state_next;
   logic [1:0]      op_reg, op_next;
   logic [7:0]      tx_reg, tx_next;
   logic [7:0]      rx_reg, rx_next;
   logic            bit_reg, bit_next;
   logic [2:0]      bit_cnt_reg, bit_cnt_next;
   logic            pres_reg, pres_next;
   logic            err_reg, err_next;
   logic            drive_reg;
   logic            rsp_valid_reg;
   logic [7:0]      rsp_data_reg, rsp_data_next;
   logic            rsp_presence_reg, rsp_presence_next;
   logic            rsp_err_reg, rsp_err_next;
   logic [1:0]      sync_reg;
   logic            line_sync;
   logic            restart;
   logic            tick;
   logic [US_W-1:0] us_count;

   // Released bus idles high, so the synchronizer resets to 1.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_reg <= 2'b11;
      end else begin
         sync_reg <= {sync_reg[0], ow_in};
      end
   end
   assign line_sync = sync_reg[1];

   // Every state entry (including command accept) starts a fresh microsecond count.
   assign restart = (state_next != state_reg);

   onewire_us_tick #(
      .CLK_PER_US (CLK_PER_US)
   ) u_us_tick (
      .clk      (clk),
      .reset_n  (reset_n),
      .restart  (restart),
      .tick     (tick),
      .us_count (us_count)
   );

   always_comb begin
      state_next        = state_reg;
      op_next           = op_reg;
      tx_next           = tx_reg;
      rx_next           = rx_reg;
      bit_next          = bit_reg;
      bit_cnt_next      = bit_cnt_reg;
      pres_next         = pres_reg;
      err_next          = err_reg;
      rsp_data_next     = rsp_data_reg;
      rsp_presence_next = rsp_presence_reg;
      rsp_err_next      = rsp_err_reg;

      unique case (state_reg)
         IDLE: begin
            if (cmd_valid) begin
               op_next      = cmd_op;
               rx_next      = '0;
               bit_cnt_next = '0;
               pres_next    = 1'b0;
               err_next     = 1'b0;
               if (cmd_op == OP_RESET) begin
                  tx_next    = cmd_data;
                  state_next = RST_LOW;
               end else begin
                  bit_next   = slot_bit(cmd_op, cmd_data[0]);
                  tx_next    = cmd_data >> 1;
                  state_next = SLOT_LOW;
               end
            end
         end
         RST_LOW: begin
            if (us_expired(tick, us_count, T_RSTL)) begin
               state_next = RST_SAMP;
            end
         end
         RST_SAMP: begin
            if (us_expired(tick, us_count, T_PRES_SAMP)) begin
               pres_next  = ~line_sync;
               state_next = RST_REC;
            end
         end
         RST_REC: begin
            if (us_expired(tick, us_count, T_RST_REC)) begin
               err_next   = err_reg | ~line_sync;
               state_next = DONE;
            end
         end
         SLOT_LOW: begin
            // A write-0 is still driven low at the sample point, so it reads back 0.
            if (!bit_reg && us_expired(tick, us_count, T_RD_SAMP)) begin
               rx_next = {line_sync, rx_reg[7:1]};
            end
            if (us_expired(tick, us_count, bit_reg ? T_LOW1 : T_LOW0)) begin
               state_next = SLOT_HIGH;
            end
         end
         SLOT_HIGH: begin
            if (bit_reg && us_expired(tick, us_count, T_RD_SAMP - T_LOW1)) begin
               rx_next = {line_sync, rx_reg[7:1]};
            end
            if (us_expired(tick, us_count, T_SLOT - (bit_reg ? T_LOW1 : T_LOW0))) begin
               state_next = SLOT_REC;
            end
         end
         SLOT_REC: begin
            if (us_expired(tick, us_count, T_REC)) begin
               err_next = err_reg | ~line_sync;
               if ((op_reg == OP_BIT) || (bit_cnt_reg == 3'd7)) begin
                  state_next = DONE;
               end else begin
                  bit_cnt_next = bit_cnt_reg + 3'd1;
                  bit_next     = slot_bit(op_reg, tx_reg[0]);
                  tx_next      = tx_reg >> 1;
                  state_next   = SLOT_LOW;
               end
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // Responses are captured on DONE entry so they are valid with rsp_valid and hold after.
      if ((state_next == DONE) && (state_reg != DONE)) begin
         rsp_err_next      = err_next;
         rsp_presence_next = (op_reg == OP_RESET) & pres_next;
         if (op_reg == OP_READ_BYTE) begin
            rsp_data_next = rx_next;
         end else if (op_reg == OP_BIT) begin
            rsp_data_next = {7'b0, rx_next[7]};
         end else begin
            rsp_data_next = 8'h00;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg        <= IDLE;
         op_reg           <= OP_RESET;
         tx_reg           <= '0;
         rx_reg           <= '0;
         bit_reg          <= 1'b0;
         bit_cnt_reg      <= '0;
         pres_reg         <= 1'b0;
         err_reg          <= 1'b0;
         drive_reg        <= 1'b0;
         rsp_valid_reg    <= 1'b0;
         rsp_data_reg     <= '0;
         rsp_presence_reg <= 1'b0;
         rsp_err_reg      <= 1'b0;
      end else begin
         state_reg        <= state_next;
         op_reg           <= op_next;
         tx_reg           <= tx_next;
         rx_reg           <= rx_next;
         bit_reg          <= bit_next;
         bit_cnt_reg      <= bit_cnt_next;
         pres_reg         <= pres_next;
         err_reg          <= err_next;
         drive_reg        <= (state_next == RST_LOW) || (state_next == SLOT_LOW);
         rsp_valid_reg    <= (state_next == DONE);
         rsp_data_reg     <= rsp_data_next;
         rsp_presence_reg <= rsp_presence_next;
         rsp_err_reg      <= rsp_err_next;
      end
   end

   assign cmd_ready    = (state_reg == IDLE);
   assign rsp_valid    = rsp_valid_reg;
   assign rsp_data     = rsp_data_reg;
   assign rsp_presence = rsp_presence_reg;
   assign rsp_err      = rsp_err_reg;
   assign ow_drive     = drive_reg;

endmodule
